// File: rtl/stack_pkg.sv
// Shared types and sizing for the stack_32 LIFO.
// The stack pointer is one bit wider than the RAM address so that "full" can be told apart from "empty".
package stack_pkg;

    localparam int STACK_WIDTH = 32;
    localparam int STACK_DEPTH = 256;
    localparam int STACK_PTR_W = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        READ_WAIT,
        DONE
    } stack_state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM for the stack storage.
// The read is registered with 1-cycle latency, and the RAM returns the old data when a read and a write hit the same address.
module stack_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
    // NOTE: storage and read register have no reset; a reset would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stack_32.sv
// LIFO stack controller: trigger edge detect, four-state transaction FSM, stack pointer and output registers.
// Each trigger edge accepted in IDLE produces exactly one push or pop, followed by a one-cycle done_out pulse.
module stack_32
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             trigger,
    input  logic [WIDTH-1:0] write_value,
    output logic [WIDTH-1:0] read_value,
    output logic             done_out,
    output logic             empty,
    output logic             full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);

    stack_state_t     state;
    stack_state_t     next_state;
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_next;
    logic             trigger_q;
    logic             start;
    logic             op_push;
    logic [WIDTH-1:0] op_data;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_rdata;

    assign empty = (sp == '0);
    assign full  = (sp == SP_FULL);

    // Edges that arrive while a transaction is in progress are dropped, not queued.
    assign start = trigger && !trigger_q && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        sp_next    = sp;
        ram_we     = 1'b0;
        ram_addr   = sp[ADDR_W-1:0];

        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (op_push) begin
                    if (!full) begin
                        ram_we  = 1'b1;
                        sp_next = sp + PTR_W'(1);
                    end
                    next_state = DONE;
                end else if (!empty) begin
                    ram_addr   = sp[ADDR_W-1:0] - ADDR_W'(1);
                    sp_next    = sp - PTR_W'(1);
                    next_state = READ_WAIT;
                end else begin
                    next_state = DONE;
                end
            end
            READ_WAIT: next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp         <= '0;
            read_value <= '0;
            done_out   <= 1'b0;
            trigger_q  <= 1'b0;
        end else begin
            sp        <= sp_next;
            done_out  <= (next_state == DONE);
            trigger_q <= trigger;
            if (state == READ_WAIT) begin
                read_value <= ram_rdata;
            end
        end
    end

    // The command is captured on the accepted edge and is only consulted in EXEC, so it needs no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            op_push <= push;
            op_data <= write_value;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (op_data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_stack_32.sv
// Directed self-checking bench for stack_32.
// Inputs change on the falling edge and outputs are sampled there too, half a cycle away from the active edge.
module tb_stack_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic        trigger;
    logic [31:0] write_value;
    logic [31:0] read_value;
    logic        done_out;
    logic        empty;
    logic        full;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stack_32 dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .trigger     (trigger),
        .write_value (write_value),
        .read_value  (read_value),
        .done_out    (done_out),
        .empty       (empty),
        .full        (full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts one operation at the current falling edge. The latency is counted in falling edges
    // until done_out is seen: 2 = done during E+2, 3 = done during E+3.
    task automatic run_op(input logic op, input logic [31:0] val, input int exp_lat, input string tag);
        int lat;
        push        = op;
        write_value = val;
        trigger     = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        lat     = 1;
        while (!done_out && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_done_width"}, {31'b0, done_out}, 32'd0);
    endtask

    task automatic pop_expect(input logic [31:0] val, input string tag);
        run_op(1'b0, 32'h0, 3, tag);
        check({tag, "_value"}, read_value, val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dones;

        rst         = 1'b1;
        push        = 1'b0;
        trigger     = 1'b0;
        write_value = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_done",  {31'b0, done_out}, 32'd0);
        check("rst_empty", {31'b0, empty},    32'd1);
        check("rst_full",  {31'b0, full},     32'd0);
        check("rst_rdval", read_value,        32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Pop on an empty stack completes early and leaves everything untouched.
        run_op(1'b0, 32'h0, 2, "pop_empty");
        check("pop_empty_rdval", read_value,     32'h0);
        check("pop_empty_empty", {31'b0, empty}, 32'd1);

        run_op(1'b1, 32'hCAFEBABE, 2, "push_cafe");
        check("push_cafe_empty", {31'b0, empty}, 32'd0);
        pop_expect(32'hCAFEBABE, "pop_cafe");
        check("pop_cafe_empty", {31'b0, empty}, 32'd1);

        run_op(1'b1, 32'hDEADBEEF, 2, "push_dead");
        run_op(1'b1, 32'hB105F00D, 2, "push_b105");
        pop_expect(32'hB105F00D, "lifo_pop1");
        pop_expect(32'hDEADBEEF, "lifo_pop2");
        check("lifo_empty", {31'b0, empty}, 32'd1);

        // Trigger held high for 10 cycles: exactly one push.
        push        = 1'b1;
        write_value = 32'h12345678;
        trigger     = 1'b1;
        dones       = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        check("held_dones", 32'(dones), 32'd1);
        pop_expect(32'h12345678, "held_pop");
        check("held_empty", {31'b0, empty}, 32'd1);

        // A second edge while a pop is in flight is ignored.
        run_op(1'b1, 32'h11111111, 2, "glitch_push1");
        run_op(1'b1, 32'h22222222, 2, "glitch_push2");
        push    = 1'b0;
        trigger = 1'b1;
        dones   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_out) dones++;
            trigger = (i == 1);
        end
        check("glitch_dones", 32'(dones),     32'd1);
        check("glitch_value", read_value,     32'h22222222);
        check("glitch_empty", {31'b0, empty}, 32'd0);
        pop_expect(32'h11111111, "glitch_pop2");
        check("glitch_empty2", {31'b0, empty}, 32'd1);

        // Fill to DEPTH, push once more on full, then drain in LIFO order.
        for (int i = 0; i < 256; i++) begin
            run_op(1'b1, 32'(i), 2, "fill_push");
        end
        check("fill_full",  {31'b0, full},  32'd1);
        check("fill_empty", {31'b0, empty}, 32'd0);
        run_op(1'b1, 32'hFFFFFFFF, 2, "push_on_full");
        check("push_on_full_full", {31'b0, full}, 32'd1);
        for (int i = 255; i >= 0; i--) begin
            pop_expect(32'(i), "drain_pop");
            if (i == 255) check("drain_not_full", {31'b0, full}, 32'd0);
        end
        check("drain_empty", {31'b0, empty}, 32'd1);

        // Reset in the EXEC cycle of a pop aborts it with no done pulse.
        run_op(1'b1, 32'h5555AAAA, 2, "pre_rst_push");
        pop_expect(32'h5555AAAA, "pre_rst_pop");
        run_op(1'b1, 32'hA5A5A5A5, 2, "mid_rst_push");
        push    = 1'b0;
        trigger = 1'b1;
        @(negedge clk);
        rst     = 1'b1;
        trigger = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dones = done_out ? 1 : 0;
        check("mid_rst_empty", {31'b0, empty}, 32'd1);
        check("mid_rst_rdval", read_value,     32'h0);
        repeat (4) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        check("mid_rst_dones", 32'(dones), 32'd0);
        run_op(1'b1, 32'h0BADF00D, 2, "post_rst_push");
        pop_expect(32'h0BADF00D, "post_rst_pop");
        check("post_rst_empty", {31'b0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
